// File: rtl/instr_sequencer.sv
// Instruction sequencer: a small FIFO feeding a three-state issue FSM that drives
// registered RAM/ALU control outputs and waits LAT cycles for multi-cycle results.
module instr_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic        we,
    output logic [3:0]  data,
    output logic [3:0]  addr,
    output logic [3:0]  addrop1,
    output logic [3:0]  addrop2,
    output logic        sel,
    output logic [1:0]  opcode,
    output logic        res_strobe,
    output logic        busy,
    output logic [7:0]  issued_cnt
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] TyWrite = 2'b00;
    localparam logic [1:0] TyRead  = 2'b01;
    localparam logic [1:0] TyAlu   = 2'b10;
    localparam logic [1:0] TyNop   = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    logic [15:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [1:0]      type_q, type_d;
    logic [3:0]      wait_q, wait_d;
    logic            we_q, we_d, sel_q, sel_d, strobe_q, strobe_d;
    logic [3:0]      data_q, data_d, addr_q, addr_d;
    logic [3:0]      addrop1_q, addrop1_d, addrop2_q, addrop2_d;
    logic [1:0]      opcode_q, opcode_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            push, pop;
    logic [15:0]     head;

    // in_ready looks only at the registered count, so a same-cycle pop cannot raise it
    assign in_ready   = count_q < CntW'(DEPTH);
    assign push       = in_valid & in_ready;
    assign pop        = (state_q == StIdle) && (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign busy       = (count_q != '0) || (state_q != StIdle);

    assign we         = we_q;
    assign data       = data_q;
    assign addr       = addr_q;
    assign addrop1    = addrop1_q;
    assign addrop2    = addrop2_q;
    assign sel        = sel_q;
    assign opcode     = opcode_q;
    assign res_strobe = strobe_q;
    assign issued_cnt = cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PtrW'(push);
        rd_ptr_d  = rd_ptr_q + PtrW'(pop);
        count_d   = count_q + CntW'(push) - CntW'(pop);
        state_d   = state_q;
        type_d    = type_q;
        wait_d    = wait_q;
        we_d      = 1'b0;
        strobe_d  = 1'b0;
        sel_d     = sel_q;
        data_d    = data_q;
        addr_d    = addr_q;
        addrop1_d = addrop1_q;
        addrop2_d = addrop2_q;
        opcode_d  = opcode_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                // Outputs are loaded on the pop edge so they are visible during ISSUE
                if (pop) begin
                    type_d  = head[15:14];
                    state_d = StIssue;
                    unique case (head[15:14])
                        TyWrite: begin
                            addr_d = head[11:8];
                            data_d = head[3:0];
                            we_d   = 1'b1;
                            sel_d  = 1'b0;
                        end
                        TyRead: begin
                            addr_d = head[11:8];
                            sel_d  = 1'b0;
                        end
                        TyAlu: begin
                            addrop1_d = head[7:4];
                            addrop2_d = head[3:0];
                            opcode_d  = head[13:12];
                            sel_d     = 1'b1;
                        end
                        TyNop: ;
                    endcase
                end
            end
            StIssue: begin
                if (type_q == TyRead || type_q == TyAlu) begin
                    state_d  = StWait;
                    wait_d   = 4'(LAT - 1);
                    strobe_d = (LAT == 1);
                end else begin
                    state_d = StIdle;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            StWait: begin
                if (wait_q == 4'd0) begin
                    state_d = StIdle;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    wait_d   = wait_q - 4'd1;
                    strobe_d = (wait_q == 4'd1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_instr;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= StIdle;
            type_q    <= TyNop;
            wait_q    <= '0;
            we_q      <= 1'b0;
            strobe_q  <= 1'b0;
            sel_q     <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            addrop1_q <= '0;
            addrop2_q <= '0;
            opcode_q  <= '0;
            cnt_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            type_q    <= type_d;
            wait_q    <= wait_d;
            we_q      <= we_d;
            strobe_q  <= strobe_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            addrop1_q <= addrop1_d;
            addrop2_q <= addrop2_d;
            opcode_q  <= opcode_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule
